// File: rtl/adr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : adr_arb_mux
// Purpose  : Registered N-channel address selector. It arbitrates in
//            round-robin or fixed-priority mode, holds the winning address
//            for HOLD cycles and pulses done in the last hold cycle.
// Revision : 1.0  initial release
// ============================================================================
module adr_arb_mux #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*WIDTH-1:0] adr_in,
  input  logic               fixed_mode,
  output logic [NCH-1:0]     gnt,
  output logic [WIDTH-1:0]   adr_out,
  output logic               adr_vld,
  output logic               done
);

  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW1 = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic [PW-1:0]    ptr_q,   ptr_d;
  logic [NCH-1:0]   gnt_q,   gnt_d;
  logic [WIDTH-1:0] adr_q,   adr_d;

  logic             done_w;
  logic             arb_edge;
  logic [NCH-1:0]   elig;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [NCH-1:0]   win_onehot;
  logic [WIDTH-1:0] win_adr;

  // Channel index visited at step k of an upward search from pointer p,
  // wrapping modulo NCH (NCH need not be a power of two).
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    logic [PW:0] s;
    s = {1'b0, p} + PW1'(k);
    if (s >= PW1'(NCH)) s = s - PW1'(NCH);
    return s[PW-1:0];
  endfunction

  // State register: all architectural state, synchronous reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      adr_q   <= adr_d;
    end
  end

  // Arbiter: the channel finishing its hold is masked out at its done edge.
  always_comb begin
    elig      = req & (done_w ? ~gnt_q : {NCH{1'b1}});
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!win_found) begin
        if (fixed_mode) begin
          if (elig[PW'(k)]) begin
            win_found = 1'b1;
            win_idx   = PW'(k);
          end
        end else if (elig[rr_idx(ptr_q, k)]) begin
          win_found = 1'b1;
          win_idx   = rr_idx(ptr_q, k);
        end
      end
    end
    win_onehot = '0;
    win_adr    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (PW'(i) == win_idx) begin
        win_onehot[i] = 1'b1;
        win_adr       = adr_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: arbitrate when idle or at the done edge, otherwise count down.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    adr_d    = adr_q;
    arb_edge = (state_q == S_IDLE) || done_w;
    if (arb_edge) begin
      if (win_found) begin
        state_d = S_GRANT;
        cnt_d   = 8'(HOLD - 1);
        gnt_d   = win_onehot;
        adr_d   = win_adr;
        ptr_d   = (win_idx == PW'(NCH - 1)) ? '0 : win_idx + PW'(1);
      end else begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        gnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Outputs: done marks the last valid hold cycle.
  always_comb begin
    done_w  = (state_q == S_GRANT) && (cnt_q == 8'd0);
    done    = done_w;
    adr_vld = (state_q == S_GRANT);
    gnt     = gnt_q;
    adr_out = adr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_adr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_adr_arb_mux
// Purpose  : Directed self-checking bench for adr_arb_mux (HOLD=2 and HOLD=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_adr_arb_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] adr_in;
  logic        fixed_mode;

  logic [3:0]  gnt_a,  gnt_b;
  logic [15:0] adr_a,  adr_b;
  logic        vld_a,  vld_b;
  logic        done_a, done_b;

  int ncmp = 0;
  int nerr = 0;

  adr_arb_mux #(.WIDTH(16), .NCH(4), .HOLD(2)) dut (
    .clk(clk), .reset(reset), .req(req), .adr_in(adr_in),
    .fixed_mode(fixed_mode), .gnt(gnt_a), .adr_out(adr_a),
    .adr_vld(vld_a), .done(done_a)
  );

  adr_arb_mux #(.WIDTH(16), .NCH(4), .HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .adr_in(adr_in),
    .fixed_mode(fixed_mode), .gnt(gnt_b), .adr_out(adr_b),
    .adr_vld(vld_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the HOLD=2 instance in one go.
  task automatic chk_a(input string tag, input logic [3:0] g, input logic [15:0] a,
                       input logic v, input logic d);
    chk({tag, ".gnt"},  {28'd0, gnt_a}, {28'd0, g});
    chk({tag, ".adr"},  {16'd0, adr_a}, {16'd0, a});
    chk({tag, ".vld"},  {31'd0, vld_a}, {31'd0, v});
    chk({tag, ".done"}, {31'd0, done_a}, {31'd0, d});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] g, input logic [15:0] a,
                       input logic v, input logic d);
    chk({tag, ".gnt"},  {28'd0, gnt_b}, {28'd0, g});
    chk({tag, ".adr"},  {16'd0, adr_b}, {16'd0, a});
    chk({tag, ".vld"},  {31'd0, vld_b}, {31'd0, v});
    chk({tag, ".done"}, {31'd0, done_b}, {31'd0, d});
  endtask

  initial begin
    reset      = 1'b1;
    req        = 4'b1111;
    fixed_mode = 1'b0;
    adr_in     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    // 1: reset held two cycles with all requests high
    tick(); chk_a("rst1", 4'b0000, 16'h0000, 1'b0, 1'b0);
    tick(); chk_a("rst2", 4'b0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    req   = 4'b0000;
    tick(); chk_a("idle", 4'b0000, 16'h0000, 1'b0, 1'b0);

    // 2: single one-edge request on ch2
    adr_in[2*16 +: 16] = 16'h1234;
    req = 4'b0100;
    tick(); req = 4'b0000;
    chk_a("single.c1", 4'b0100, 16'h1234, 1'b1, 1'b0);
    tick(); chk_a("single.c2", 4'b0100, 16'h1234, 1'b1, 1'b1);
    tick(); chk_a("single.end", 4'b0000, 16'h1234, 1'b0, 1'b0);

    // 3: round-robin from pointer 0, back-to-back grants
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) adr_in[i*16 +: 16] = 16'hA000 + 16'(i);
    fixed_mode = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(); chk_a($sformatf("rr%0d.c1", g), 4'(1 << (g % 4)), 16'hA000 + 16'(g % 4), 1'b1, 1'b0);
      tick(); chk_a($sformatf("rr%0d.c2", g), 4'(1 << (g % 4)), 16'hA000 + 16'(g % 4), 1'b1, 1'b1);
    end
    req = 4'b0000;
    tick(); chk_a("rr.idle", 4'b0000, 16'hA000, 1'b0, 1'b0);

    // 4: fixed priority with everyone requesting alternates ch0/ch1
    fixed_mode = 1'b1;
    req = 4'b1111;
    tick(); chk_a("fx0.c1", 4'b0001, 16'hA000, 1'b1, 1'b0);
    tick(); chk_a("fx0.c2", 4'b0001, 16'hA000, 1'b1, 1'b1);
    tick(); chk_a("fx1.c1", 4'b0010, 16'hA001, 1'b1, 1'b0);
    tick(); chk_a("fx1.c2", 4'b0010, 16'hA001, 1'b1, 1'b1);
    tick(); chk_a("fx2.c1", 4'b0001, 16'hA000, 1'b1, 1'b0);
    tick(); chk_a("fx2.c2", 4'b0001, 16'hA000, 1'b1, 1'b1);
    tick(); chk_a("fx3.c1", 4'b0010, 16'hA001, 1'b1, 1'b0);
    tick(); chk_a("fx3.c2", 4'b0010, 16'hA001, 1'b1, 1'b1);
    // only ch0: grant, idle bubble from masking, grant again
    req = 4'b0001;
    tick(); chk_a("solo0.c1", 4'b0001, 16'hA000, 1'b1, 1'b0);
    tick(); chk_a("solo0.c2", 4'b0001, 16'hA000, 1'b1, 1'b1);
    tick(); chk_a("solo.gap", 4'b0000, 16'hA000, 1'b0, 1'b0);
    tick(); chk_a("solo1.c1", 4'b0001, 16'hA000, 1'b1, 1'b0);
    req = 4'b0000;
    tick(); chk_a("solo1.c2", 4'b0001, 16'hA000, 1'b1, 1'b1);
    tick(); chk_a("solo.idle", 4'b0000, 16'hA000, 1'b0, 1'b0);

    // 6: adr_in changes mid-hold are ignored
    fixed_mode = 1'b0;
    adr_in[1*16 +: 16] = 16'h0F00;
    req = 4'b0010;
    tick();
    adr_in[1*16 +: 16] = 16'hFFFF;
    req = 4'b0000;
    chk_a("cap.c1", 4'b0010, 16'h0F00, 1'b1, 1'b0);
    tick(); chk_a("cap.c2", 4'b0010, 16'h0F00, 1'b1, 1'b1);
    tick(); chk_a("cap.idle", 4'b0000, 16'h0F00, 1'b0, 1'b0);

    // 5: HOLD=4, reset during the second hold cycle of a ch3 grant
    reset = 1'b1; tick(); reset = 1'b0;
    adr_in = {16'h3003, 16'h2002, 16'h1001, 16'h5555};
    req = 4'b1000;
    tick(); chk_b("h4.c1", 4'b1000, 16'h3003, 1'b1, 1'b0);
    tick(); chk_b("h4.c2", 4'b1000, 16'h3003, 1'b1, 1'b0);
    reset = 1'b1;
    req   = 4'b1111;
    tick(); chk_b("h4.abort", 4'b0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); chk_b("h4.g0c1", 4'b0001, 16'h5555, 1'b1, 1'b0);
    tick(); chk_b("h4.g0c2", 4'b0001, 16'h5555, 1'b1, 1'b0);
    tick(); chk_b("h4.g0c3", 4'b0001, 16'h5555, 1'b1, 1'b0);
    tick(); chk_b("h4.g0c4", 4'b0001, 16'h5555, 1'b1, 1'b1);
    tick(); chk_b("h4.g1c1", 4'b0010, 16'h1001, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adr_arb_mux.md
Name: adr_arb_mux

Overview:
Parametrised, registered N-channel address selector for the CPU execution unit. Several address sources (PC, MAR, SP, DMA) can request the memory address bus. The block arbitrates between them in round-robin or fixed-priority mode. It latches the winning address and holds it on the bus for a programmable number of cycles, then signals completion.

Parameters:
WIDTH, 16, address width in bits
NCH, 4, number of requesting channels (2..8)
HOLD, 2, cycles each granted address is held on adr_out (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  NCH  per-channel request; bit i = channel i
adr_in  input  NCH*WIDTH  channel addresses; channel i at bits [i*WIDTH +: WIDTH]
fixed_mode  input  1  1 = fixed priority (ch0 highest), 0 = round-robin
gnt  output  NCH  one-hot grant, registered
adr_out  output  WIDTH  registered selected address
adr_vld  output  1  adr_out is valid for the granted channel
done  output  1  single-cycle pulse during the last hold cycle

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- On reset at the clock edge: gnt=0, adr_out=0, adr_vld=0, done=0, state=IDLE, hold counter=0, round-robin pointer=0. Any in-progress grant is aborted and no done is issued. Reset takes priority over all other events.
- FSM has two states, IDLE and GRANT.
- IDLE: at each edge, if any eligible req bit is high, select a winner and go to GRANT.
  - gnt gets the winner's one-hot bit.
  - adr_out gets that channel's adr_in.
  - adr_vld=1; counter=HOLD-1.
  - If no eligible req bit is high, stay in IDLE with gnt=0 and adr_vld=0; adr_out keeps its last value.
- Latency: a request sampled at edge k produces valid gnt, adr_out and adr_vld in cycles k+1 .. k+HOLD, i.e. exactly HOLD cycles.
- GRANT: the counter decrements each edge. done=1 while counter==0 (the last valid cycle); with HOLD=1, done is high in the single valid cycle.
- At the edge where done==1, arbitrate again (back-to-back grants, no idle bubble):
  - If an eligible request exists, load the next grant.
  - Otherwise go to IDLE and clear gnt and adr_vld.
- Handshake:
  - The requester holds req until it observes done, and may drop req after that edge.
  - At the done edge the just-granted channel is masked out of arbitration. It is eligible again from the following edge.
  - Deasserting req during GRANT does not shorten or abort the grant.
- Selection rules:
  - Round-robin (fixed_mode=0): search upward from the pointer, wrapping modulo NCH. After each grant, pointer = winner+1 (mod NCH).
  - Fixed priority (fixed_mode=1): the lowest eligible index wins. The pointer still updates.
  - fixed_mode is sampled only at arbitration edges.
- adr_in is captured only at the grant edge. Changes to adr_in during GRANT do not affect adr_out.
- Invariants: gnt is always zero or one-hot; adr_vld == |gnt; done implies adr_vld.

Test Plan:
1. NCH=4, HOLD=2: hold reset for 2 cycles with req=4'b1111 -> gnt=0, adr_out=16'h0000, adr_vld=0, done=0 throughout.
2. req=4'b0100 for one edge, ch2 adr=16'h1234 -> gnt=4'b0100 and adr_out=16'h1234 with adr_vld high for exactly 2 cycles; done high in the 2nd cycle only; then gnt=0, adr_vld=0, adr_out stays 16'h1234.
3. fixed_mode=0, req=4'b1111 held, adr of ch i = 16'hA000+i -> grants 0,1,2,3,0 back-to-back with no idle cycle; adr_out=A000,A001,A002,A003,A000; one done per grant.
4. fixed_mode=1, req=4'b1111 held -> grant sequence 0,1,0,1 (the granted channel is masked at its done edge); only ch0 requesting -> grant, one idle cycle, grant again.
5. HOLD=4: reset asserted during the 2nd hold cycle of a ch3 grant -> next edge all outputs zero and no done pulse; after release with req=4'b1111, round-robin restarts at ch0.
6. Grant ch1 with adr=16'h0F00, then change adr_in ch1 to 16'hFFFF mid-hold -> adr_out stays 16'h0F00 until done.
